// File: rtl/dcache_wbb_l2_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_wbb_l2_wb_ctrl
// Description : Write-back controller between the L1 D-cache victim buffer
//               (WBB) and the L2 request/answer arbiter. Picks the next ready
//               victim, tags it, issues it to L2, and on each L2 answer tells
//               the WBB to retire (clr) or re-arm (wup) the matching entry.
//               Owns the write-back tag counter and the in-flight count.
// Options     : `define DCACHE_WBB_PERF_EN adds saturating completion / nack
//               counters; otherwise the perf ports are tied to zero.
// Ports       : clk_i, rst_ni (sync, active-low)
//               d1_busy_i                - D1 owns the WBB port this cycle
//               wbb_req_available_i,
//               wbb_line_i, wbb_line_addr_i - next ready victim from the WBB
//               wbb_put_wait_o, wbb_new_tag_o - park entry + assign tag
//               wbb_tag_cmp_o / wbb_tag_hit_i  - WBB tag lookup
//               wbb_clr_o, wbb_wup_o     - retire / wake the hit entry
//               l2_req_*                 - valid/ready write-back request
//               l2_ans_*                 - valid/ready tagged answer
//               outst_o, err_o           - in-flight count, sticky error
//               perf_wb_cnt_o, perf_nack_cnt_o - optional perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_wbb_l2_wb_ctrl #(
    parameter  int LINE_W    = 512,
    parameter  int LADDR_W   = 26,
    parameter  int TAG_W     = 4,
    parameter  int MAX_OUTST = 4,
    localparam int OUTST_W   = $clog2(MAX_OUTST + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                d1_busy_i,
    input  logic                wbb_req_available_i,
    input  logic [LINE_W-1:0]   wbb_line_i,
    input  logic [LADDR_W-1:0]  wbb_line_addr_i,
    output logic                wbb_put_wait_o,
    output logic [TAG_W-1:0]    wbb_new_tag_o,
    output logic [TAG_W-1:0]    wbb_tag_cmp_o,
    input  logic                wbb_tag_hit_i,
    output logic                wbb_clr_o,
    output logic                wbb_wup_o,
    output logic                l2_req_valid_o,
    input  logic                l2_req_ready_i,
    output logic [LINE_W-1:0]   l2_req_line_o,
    output logic [LADDR_W-1:0]  l2_req_addr_o,
    output logic [TAG_W-1:0]    l2_req_tag_o,
    input  logic                l2_ans_valid_i,
    output logic                l2_ans_ready_o,
    input  logic [TAG_W-1:0]    l2_ans_tag_i,
    input  logic                l2_ans_ok_i,
    output logic [OUTST_W-1:0]  outst_o,
    output logic                err_o,
    output logic [31:0]         perf_wb_cnt_o,
    output logic [31:0]         perf_nack_cnt_o
);

    localparam logic [OUTST_W-1:0] c_max_outst = OUTST_W'(MAX_OUTST);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               r_state;
    logic [TAG_W-1:0]     r_tag;
    logic [OUTST_W-1:0]   r_outst;
    logic                 r_err;
    logic [LINE_W-1:0]    r_line;
    logic [LADDR_W-1:0]   r_addr;
    logic [TAG_W-1:0]     r_req_tag;

    logic w_ans_ready;
    logic w_ans_hs;
    logic w_outst_nz;
    logic w_ans_good;
    logic w_ans_bad;
    logic w_start;

    // Answers are taken whenever D1 does not own the WBB port; held off
    // during reset so no WBB command can escape while state is being cleared.
    assign w_ans_ready = rst_ni & ~d1_busy_i;
    assign w_ans_hs    = l2_ans_valid_i & w_ans_ready;
    assign w_outst_nz  = (r_outst != '0);
    // An answer only acts on the WBB if it matches a parked entry and we
    // actually have something in flight; anything else is a protocol error.
    assign w_ans_good  = w_ans_hs & wbb_tag_hit_i & w_outst_nz;
    assign w_ans_bad   = w_ans_hs & ~(wbb_tag_hit_i & w_outst_nz);

    // Answer path owns the WBB port when it handshakes, so a new issue waits;
    // this also makes outst increment and decrement mutually exclusive.
    assign w_start = rst_ni & (r_state == ST_IDLE) & wbb_req_available_i &
                     ~d1_busy_i & (r_outst < c_max_outst) & ~w_ans_hs;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_tag     <= '0;
            r_outst   <= '0;
            r_err     <= 1'b0;
            r_line    <= '0;
            r_addr    <= '0;
            r_req_tag <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state   <= ST_REQ;
                        r_line    <= wbb_line_i;
                        r_addr    <= wbb_line_addr_i;
                        r_req_tag <= r_tag;
                    end
                end
                ST_REQ: begin
                    if (l2_req_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_start) begin
                r_tag <= r_tag + TAG_W'(1);
            end

            if (w_start) begin
                r_outst <= r_outst + OUTST_W'(1);
            end else if (w_ans_good) begin
                r_outst <= r_outst - OUTST_W'(1);
            end

            if (w_ans_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wbb_put_wait_o = w_start;
    assign wbb_new_tag_o  = r_tag;
    assign wbb_tag_cmp_o  = l2_ans_tag_i;
    assign wbb_clr_o      = w_ans_good & l2_ans_ok_i;
    assign wbb_wup_o      = w_ans_good & ~l2_ans_ok_i;

    assign l2_req_valid_o = (r_state == ST_REQ);
    assign l2_req_line_o  = r_line;
    assign l2_req_addr_o  = r_addr;
    assign l2_req_tag_o   = r_req_tag;
    assign l2_ans_ready_o = w_ans_ready;

    assign outst_o = r_outst;
    assign err_o   = r_err;

`ifdef DCACHE_WBB_PERF_EN
    logic [31:0] r_perf_wb;
    logic [31:0] r_perf_nack;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_perf_wb   <= '0;
            r_perf_nack <= '0;
        end else begin
            if (w_ans_good && l2_ans_ok_i && (r_perf_wb != 32'hFFFF_FFFF)) begin
                r_perf_wb <= r_perf_wb + 32'd1;
            end
            if (w_ans_good && !l2_ans_ok_i && (r_perf_nack != 32'hFFFF_FFFF)) begin
                r_perf_nack <= r_perf_nack + 32'd1;
            end
        end
    end

    assign perf_wb_cnt_o   = r_perf_wb;
    assign perf_nack_cnt_o = r_perf_nack;
`else
    assign perf_wb_cnt_o   = '0;
    assign perf_nack_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_wbb_l2_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_wbb_l2_wb_ctrl
// Description : Randomized bench for dcache_wbb_l2_wb_ctrl. A driver applies
//               random WBB / L2 traffic each cycle and, from a set-based
//               reference model (in-flight tag set, pending-request flag,
//               next tag), pushes the expected per-cycle response and the
//               expected L2 requests into queues. A monitor pops and compares.
//               The WBB itself is modelled as a bitmap of parked tags that
//               answers the tag lookup combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_wbb_l2_wb_ctrl;

    localparam int LINE_W    = 512;
    localparam int LADDR_W   = 26;
    localparam int TAG_W     = 4;
    localparam int MAX_OUTST = 4;
    localparam int NTAGS     = 1 << TAG_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                busy;
    logic                avail;
    logic [LINE_W-1:0]   line;
    logic [LADDR_W-1:0]  addr;
    logic                put_wait;
    logic [TAG_W-1:0]    new_tag;
    logic [TAG_W-1:0]    tag_cmp;
    logic                tag_hit;
    logic                clr;
    logic                wup;
    logic                req_valid;
    logic                req_ready;
    logic [LINE_W-1:0]   req_line;
    logic [LADDR_W-1:0]  req_addr;
    logic [TAG_W-1:0]    req_tag;
    logic                ans_valid;
    logic                ans_ready;
    logic [TAG_W-1:0]    ans_tag;
    logic                ans_ok;
    logic [2:0]          outst;
    logic                err;
    logic [31:0]         perf_wb;
    logic [31:0]         perf_nack;

    logic [NTAGS-1:0]    wbb_waiting;
    assign tag_hit = wbb_waiting[tag_cmp];

    always #5 clk = ~clk;

    dcache_wbb_l2_wb_ctrl #(
        .LINE_W    (LINE_W),
        .LADDR_W   (LADDR_W),
        .TAG_W     (TAG_W),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .d1_busy_i           (busy),
        .wbb_req_available_i (avail),
        .wbb_line_i          (line),
        .wbb_line_addr_i     (addr),
        .wbb_put_wait_o      (put_wait),
        .wbb_new_tag_o       (new_tag),
        .wbb_tag_cmp_o       (tag_cmp),
        .wbb_tag_hit_i       (tag_hit),
        .wbb_clr_o           (clr),
        .wbb_wup_o           (wup),
        .l2_req_valid_o      (req_valid),
        .l2_req_ready_i      (req_ready),
        .l2_req_line_o       (req_line),
        .l2_req_addr_o       (req_addr),
        .l2_req_tag_o        (req_tag),
        .l2_ans_valid_i      (ans_valid),
        .l2_ans_ready_o      (ans_ready),
        .l2_ans_tag_i        (ans_tag),
        .l2_ans_ok_i         (ans_ok),
        .outst_o             (outst),
        .err_o               (err),
        .perf_wb_cnt_o       (perf_wb),
        .perf_nack_cnt_o     (perf_nack)
    );

    typedef struct {
        bit          put;
        bit          clr;
        bit          wup;
        bit [3:0]    new_tag;
        bit [3:0]    cmp_tag;
        bit          ans_rdy;
        bit          chk_rdy;
        bit          chk_reg;
        bit          rst;
        bit          req_valid;
        int          outst;
        bit          err;
        bit [31:0]   pwb;
        bit [31:0]   pnack;
    } exp_t;

    typedef struct {
        logic [LINE_W-1:0]  line;
        logic [LADDR_W-1:0] addr;
        logic [TAG_W-1:0]   tag;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [NTAGS-1:0] m_infl;
    int               m_outst;
    bit               m_pending;
    bit [3:0]         m_tag;
    bit               m_err;
    bit               m_known;
    bit               m_hold;
    bit [31:0]        m_wb;
    bit [31:0]        m_nack;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 random traffic, 1 reset, 2 answer with an unknown tag, 3 quiet
    task automatic drive_cycle(input int mode);
        exp_t e;
        req_t rq;
        bit   hs;
        bit   good;
        bit   start;
        int   k;
        @(negedge clk);
        wbb_waiting = m_infl;
        rst_n = (mode != 1);
        if (mode == 0) begin
            busy      = ($urandom_range(0, 4) == 0);
            avail     = ($urandom_range(0, 9) < 6);
            req_ready = ($urandom_range(0, 2) == 0);
        end else begin
            busy      = 1'b0;
            avail     = 1'b0;
            req_ready = 1'b1;
        end
        for (int i = 0; i < LINE_W / 32; i++) line[i*32 +: 32] = $urandom;
        addr = LADDR_W'($urandom);

        if (mode == 2) begin
            k = 0;
            while (m_infl[k]) k++;
            ans_valid = 1'b1;
            ans_ok    = 1'b1;
            ans_tag   = 4'(k);
            m_hold    = 1'b0;
        end else if (mode == 0 && m_hold) begin
            // L2 keeps presenting an answer that was not yet accepted
            ans_valid = 1'b1;
        end else if (mode == 0 && m_outst > 0 && $urandom_range(0, 2) == 0) begin
            k = $urandom_range(0, NTAGS - 1);
            while (!m_infl[k]) k = (k + 1) % NTAGS;
            ans_valid = 1'b1;
            ans_tag   = 4'(k);
            ans_ok    = ($urandom_range(0, 3) != 0);
        end else begin
            ans_valid = 1'b0;
            ans_tag   = 4'($urandom);
            ans_ok    = 1'($urandom);
            m_hold    = 1'b0;
        end
        #1;

        hs    = ans_valid && !busy && rst_n;
        good  = hs && m_infl[ans_tag] && (m_outst > 0);
        start = rst_n && !m_pending && avail && !busy && (m_outst < MAX_OUTST) && !hs;

        e.put       = start;
        e.clr       = good && ans_ok;
        e.wup       = good && !ans_ok;
        e.new_tag   = m_tag;
        e.cmp_tag   = ans_tag;
        e.ans_rdy   = !busy;
        e.chk_rdy   = rst_n;
        e.chk_reg   = m_known;
        e.rst       = !rst_n;
        e.req_valid = m_pending;
        e.outst     = m_outst;
        e.err       = m_err;
`ifdef DCACHE_WBB_PERF_EN
        e.pwb       = m_wb;
        e.pnack     = m_nack;
`else
        e.pwb       = 32'd0;
        e.pnack     = 32'd0;
`endif
        exp_q.push_back(e);

        if (start) begin
            rq.line = line;
            rq.addr = addr;
            rq.tag  = m_tag;
            req_q.push_back(rq);
        end

        // advance the model across the coming clock edge
        if (!rst_n) begin
            m_infl    = '0;
            m_outst   = 0;
            m_pending = 1'b0;
            m_tag     = 4'd0;
            m_err     = 1'b0;
            m_wb      = 32'd0;
            m_nack    = 32'd0;
            m_hold    = 1'b0;
            m_known   = 1'b1;
        end else begin
            m_hold = ans_valid && !hs && (mode == 0);
            if (hs) begin
                if (good) begin
                    m_infl[ans_tag] = 1'b0;
                    m_outst--;
                    if (ans_ok) m_wb++;
                    else        m_nack++;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (m_pending && req_ready) m_pending = 1'b0;
            if (start) begin
                m_pending      = 1'b1;
                m_infl[m_tag]  = 1'b1;
                m_outst++;
                m_tag          = m_tag + 4'd1;
            end
        end
    endtask

    // Monitor: pops one expected row per cycle and checks the DUT response
    initial begin
        exp_t r;
        req_t q;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("put_wait", put_wait, r.put);
                if (r.put) chk("new_tag", new_tag, r.new_tag);
                chk("wbb_clr", clr, r.clr);
                chk("wbb_wup", wup, r.wup);
                chk("tag_cmp", tag_cmp, r.cmp_tag);
                if (r.chk_rdy) chk("ans_ready", ans_ready, r.ans_rdy);
                if (r.chk_reg) begin
                    chk("req_valid", req_valid, r.req_valid);
                    chk("outst", outst, r.outst);
                    chk("err", err, r.err);
                    chk("perf_wb", perf_wb, r.pwb);
                    chk("perf_nack", perf_nack, r.pnack);
                    if (req_valid === 1'b1) begin
                        if (req_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL req_payload: request valid but none expected at %0t", $time);
                        end else begin
                            q = req_q[0];
                            chk("req_addr", req_addr, q.addr);
                            chk("req_tag", req_tag, q.tag);
                            n_tests++;
                            if (req_line !== q.line) begin
                                n_fail++;
                                $display("FAIL req_line: got %h expected %h", req_line[127:0], q.line[127:0]);
                            end
                            if (req_ready) void'(req_q.pop_front());
                        end
                    end
                end
                if (r.rst) req_q.delete();
            end
        end
    end

    initial begin
        int guard;
        rst_n      = 1'b0;
        busy       = 1'b0;
        avail      = 1'b0;
        line       = '0;
        addr       = '0;
        req_ready  = 1'b0;
        ans_valid  = 1'b0;
        ans_tag    = '0;
        ans_ok     = 1'b0;
        m_infl     = '0;
        wbb_waiting = '0;
        m_outst    = 0;
        m_pending  = 1'b0;
        m_tag      = 4'd0;
        m_err      = 1'b0;
        m_known    = 1'b0;
        m_hold     = 1'b0;
        m_wb       = 32'd0;
        m_nack     = 32'd0;

        repeat (3) drive_cycle(1);
        repeat (1500) drive_cycle(0);

        // reset while a request is being presented to L2
        guard = 0;
        while (!m_pending && guard < 200) begin
            drive_cycle(0);
            guard++;
        end
        repeat (2) drive_cycle(1);
        repeat (1500) drive_cycle(0);

        // drain, then an answer nobody is waiting for: sticky error
        repeat (4) drive_cycle(3);
        drive_cycle(2);
        repeat (5) drive_cycle(3);
        repeat (2) drive_cycle(1);
        repeat (3) drive_cycle(3);

        repeat (3) @(negedge clk);
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected rows left unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_wbb_l2_wb_ctrl.md
Name: dcache_wbb_l2_wb_ctrl

Overview:
- Downstream consumer of the L1 D-cache write-back victim buffer (WBB).
- Picks the next ready victim line and issues a tagged write-back request to the L2 cache.
- Tracks outstanding write-backs and, on each L2 answer, tells the WBB to retire the entry (ack) or re-arm it for retry (nack).
- Sits between the WBB and the L2 request/answer arbiter; owns the write-back tag counter.

Parameters:
- LINE_W, 512, cache line width in bits.
- LADDR_W, 26, line address width.
- TAG_W, 4, write-back tag width; tags wrap modulo 2^TAG_W.
- MAX_OUTST, 4, max in-flight write-backs; must be ≤ 2^TAG_W and ≤ WBB entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- d1_busy_i  in  1  D1 controller owns the WBB command/compare port this cycle.
- wbb_req_available_i  in  1  WBB has a valid, non-waiting entry.
- wbb_line_i  in  LINE_W  next ready line from WBB.
- wbb_line_addr_i  in  LADDR_W  next ready line address from WBB.
- wbb_put_wait_o  out  1  mark next-ready entry waiting and store wbb_new_tag_o.
- wbb_new_tag_o  out  TAG_W  tag assigned to the entry.
- wbb_tag_cmp_o  out  TAG_W  tag driven to the WBB comparator.
- wbb_tag_hit_i  in  1  WBB tag hit result, combinational from wbb_tag_cmp_o.
- wbb_clr_o  out  1  clear the hit entry.
- wbb_wup_o  out  1  wake up the hit entry for retry.
- l2_req_valid_o  out  1  write-back request valid.
- l2_req_ready_i  in  1  L2 accepts the request.
- l2_req_line_o  out  LINE_W  request data.
- l2_req_addr_o  out  LADDR_W  request line address.
- l2_req_tag_o  out  TAG_W  request tag.
- l2_ans_valid_i  in  1  L2 answer valid.
- l2_ans_ready_o  out  1  answer accepted.
- l2_ans_tag_i  in  TAG_W  answer tag.
- l2_ans_ok_i  in  1  1 = written, 0 = nack (retry).
- outst_o  out  $clog2(MAX_OUTST+1)  in-flight count.
- err_o  out  1  sticky protocol error.
- perf_wb_cnt_o  out  32  completed write-backs (optional feature).
- perf_nack_cnt_o  out  32  nacks received (optional feature).

Behaviour:
- Reset: synchronous, active-low.
  - FSM to IDLE; tag counter = 0; outst_o = 0; err_o = 0.
  - Request payload registers and perf counters = 0.
  - All outputs deasserted. Reset mid-request drops l2_req_valid_o at the same edge.
- WBB command exclusivity: at most one of wbb_put_wait_o, wbb_clr_o, wbb_wup_o high per cycle, and none while d1_busy_i = 1.
  - Integration rule: the D1 controller drives no valid compare address into the WBB while d1_busy_i = 0.
- Answer path (priority over new requests):
  - l2_ans_ready_o = !d1_busy_i.
  - wbb_tag_cmp_o = l2_ans_tag_i, combinational.
  - On answer handshake with wbb_tag_hit_i = 1:
    - ok = 1: wbb_clr_o = 1.
    - ok = 0: wbb_wup_o = 1.
    - outst decrements at the edge.
  - Hit = 0, or outst = 0: set err_o; drop the answer; no WBB command.
- Request FSM:
  - IDLE → REQ when wbb_req_available_i & !d1_busy_i & outst < MAX_OUTST & no answer handshake this cycle.
    - In that cycle: wbb_put_wait_o = 1 and wbb_new_tag_o = tag counter.
    - At the edge: latch wbb_line_i / wbb_line_addr_i / tag into the l2_req_* registers; tag counter +1 with wrap; outst +1.
  - REQ: l2_req_valid_o = 1 with payload held stable; on l2_req_ready_i go to IDLE.
    - The next request can start one cycle later (no back-to-back issue).
  - Answers are accepted in any FSM state, including before the request handshake completes.
- outst never exceeds MAX_OUTST; increment and decrement are mutually exclusive by construction.
- Tag counter wraps from 2^TAG_W−1 to 0; uniqueness is guaranteed by the MAX_OUTST constraint.

Optional Feature:
- DCACHE_WBB_PERF_EN defined:
  - perf_wb_cnt_o +1 on each ok answer with a tag hit.
  - perf_nack_cnt_o +1 on each nack with a tag hit.
  - Both counters saturate at 2^32−1 and reset to 0.
- Not defined: both ports tied to 0; no counter flops.

Test Plan:
- Reset, then available = 1, addr = 0x0000123 → wbb_put_wait_o pulse with tag 0; next cycle l2_req_valid_o = 1, addr 0x0000123, tag 0; ready after 3 cycles → payload stable throughout, outst = 1.
- Answer tag 0, ok = 1, tag_hit = 1 → wbb_clr_o for 1 cycle, outst 1→0, err_o = 0.
- Answer tag 2, ok = 0, hit = 1 → wbb_wup_o only; with the perf macro defined, perf_nack_cnt_o = 1.
- Issue 4 requests with L2 silent → 5th blocked (no put_wait) while available = 1; one ok answer → 5th issues with tag 4.
- Answer valid and available in the same cycle → answer served first, put_wait the following cycle.
- d1_busy_i = 1 while answer valid → l2_ans_ready_o = 0 and no WBB command; answer tag with hit = 0 → err_o sticky until reset. 17 total issues → tag wraps 15→0.
